// File: rtl/dm_responder.sv
// Data-memory responder with a fixed wait-state count and a stall/done/err handshake
// toward a pipelined core's MEM stage.
module dm_responder #(
    parameter int ADDR_W      = 6,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    output logic [31:0] DM_data,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [31:0] addr_reg;
    logic [31:0] data_reg;
    logic        rd_reg;
    logic        wr_reg;
    logic        err_flag_reg;
    logic [31:0] dm_data_reg;

    logic [31:0] mem [DEPTH];
    logic [DEPTH-1:0] valid_reg;

    logic              req;
    logic              enter_resp;
    logic [31:0]       op_addr;
    logic [31:0]       op_data;
    logic              op_rd;
    logic              op_wr;
    logic [ADDR_W-1:0] op_idx;
    logic              op_err;
    logic              mem_we;
    logic              rd_load;

    assign req = MemRead | MemWrite;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // With no wait states the access happens on the accept edge itself, so the
    // live inputs stand in for the captured request while still in IDLE.
    assign op_addr = (state_reg == IDLE) ? addr     : addr_reg;
    assign op_data = (state_reg == IDLE) ? data     : data_reg;
    assign op_rd   = (state_reg == IDLE) ? MemRead  : rd_reg;
    assign op_wr   = (state_reg == IDLE) ? MemWrite : wr_reg;
    assign op_idx  = op_addr[ADDR_W+1:2];

    assign op_err = (op_addr[1:0] != 2'b00)
                  | (|op_addr[31:ADDR_W+2])
                  | (op_rd & op_wr);

    assign enter_resp = !rst && (state_reg != RESP) && (state_next == RESP);
    assign mem_we     = enter_resp && op_wr && !op_err;
    assign rd_load    = enter_resp && op_rd && !op_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg     <= 32'd0;
            data_reg     <= 32'd0;
            rd_reg       <= 1'b0;
            wr_reg       <= 1'b0;
            err_flag_reg <= 1'b0;
        end else begin
            if (state_reg == IDLE && req) begin
                addr_reg <= addr;
                data_reg <= data;
                rd_reg   <= MemRead;
                wr_reg   <= MemWrite;
            end
            if (enter_resp) begin
                err_flag_reg <= op_err;
            end
        end
    end

    // Storage array has no reset; per-word valid bits make a reset read back as zero.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[op_idx] <= op_data;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg[gi] <= 1'b0;
                end else if (mem_we && op_idx == ADDR_W'(gi)) begin
                    valid_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            dm_data_reg <= 32'd0;
        end else if (rd_load) begin
            dm_data_reg <= valid_reg[op_idx] ? mem[op_idx] : 32'd0;
        end
    end

    assign DM_data = dm_data_reg;
    assign busy    = !rst && ((state_reg == IDLE && req) || state_reg == WAIT);
    assign done    = (state_reg == RESP);
    assign err     = (state_reg == RESP) && err_flag_reg;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: a WAIT_CYCLES=2 instance for single transactions
// and a WAIT_CYCLES=0 instance for back-to-back held requests.
module tb_dm_responder;

    logic        clk;
    logic        rst;
    logic        mem_read, mem_write;
    logic [31:0] addr, data;
    logic [31:0] dm_data;
    logic        busy, done, err;

    logic        mem_read0, mem_write0;
    logic [31:0] addr0, data0;
    logic [31:0] dm_data0;
    logic        busy0, done0, err0;

    int check_cnt = 0;
    int pass_cnt  = 0;

    dm_responder #(.ADDR_W(6), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst), .MemRead(mem_read), .MemWrite(mem_write),
        .addr(addr), .data(data), .DM_data(dm_data),
        .busy(busy), .done(done), .err(err)
    );

    dm_responder #(.ADDR_W(6), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .MemRead(mem_read0), .MemWrite(mem_write0),
        .addr(addr0), .data(data0), .DM_data(dm_data0),
        .busy(busy0), .done(done0), .err(err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one request for a single cycle, then scrambles the inputs and
    // measures cycles from the request cycle to done.
    task automatic issue_op(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] d, output int lat, output int busy_cnt,
                            output logic err_seen, output logic done_after);
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; addr = a; data = d;
        @(negedge clk);
        busy_cnt = busy ? 1 : 0;
        lat = -1;
        err_seen = 1'b0;
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0; addr = 32'hFFFF_FFFF; data = 32'h0BAD_0BAD;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                lat = i;
                err_seen = err;
                break;
            end
        end
        @(negedge clk);
        done_after = done;
    endtask

    task automatic test_reset;
        @(posedge clk); #1;
        rst = 1'b1; mem_read = 1'b1; mem_read0 = 1'b1;
        @(negedge clk);
        check_cnt++;
        if (busy !== 1'b0 || busy0 !== 1'b0)
            $display("FAIL reset_busy: got %b/%b expected 0/0", busy, busy0);
        else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0; mem_read = 1'b0; mem_read0 = 1'b0;
        @(negedge clk);
        check_cnt++;
        if (done !== 1'b0 || err !== 1'b0)
            $display("FAIL reset_done_err: got done=%b err=%b expected 0 0", done, err);
        else pass_cnt++;
        check_cnt++;
        if (dm_data !== 32'h0)
            $display("FAIL reset_dm_data: got %h expected 00000000", dm_data);
        else pass_cnt++;
        check_cnt++;
        if (busy !== 1'b0)
            $display("FAIL reset_idle_busy: got %b expected 0", busy);
        else pass_cnt++;
        $display("reset: busy=%b done=%b err=%b DM_data=%h", busy, done, err, dm_data);
    endtask

    // Runs one transaction on the WAIT_CYCLES=2 instance and checks handshake and data.
    task automatic test_op(input string name, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic exp_err, input logic [31:0] exp_dm);
        int lat, bcnt;
        logic e, da;
        issue_op(rd, wr, a, d, lat, bcnt, e, da);
        check_cnt++;
        if (lat !== 3) $display("FAIL %s_latency: got %0d expected 3", name, lat);
        else pass_cnt++;
        check_cnt++;
        if (bcnt !== 3) $display("FAIL %s_busy_cycles: got %0d expected 3", name, bcnt);
        else pass_cnt++;
        check_cnt++;
        if (e !== exp_err) $display("FAIL %s_err: got %b expected %b", name, e, exp_err);
        else pass_cnt++;
        check_cnt++;
        if (da !== 1'b0) $display("FAIL %s_done_pulse: done still %b a cycle later, expected 0", name, da);
        else pass_cnt++;
        check_cnt++;
        if (dm_data !== exp_dm) $display("FAIL %s_dm_data: got %h expected %h", name, dm_data, exp_dm);
        else pass_cnt++;
        $display("%s: rd=%b wr=%b addr=%h data=%h lat=%0d busy_cycles=%0d err=%b DM_data=%h",
                 name, rd, wr, a, d, lat, bcnt, e, dm_data);
    endtask

    task automatic test_write_read;
        test_op("write_10", 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0);
        test_op("read_10",  1'b1, 1'b0, 32'h10, 32'h0,         1'b0, 32'hDEAD_BEEF);
        test_op("write_14", 1'b0, 1'b1, 32'h14, 32'h1111_1111, 1'b0, 32'hDEAD_BEEF);
    endtask

    task automatic test_errors;
        test_op("read_misaligned", 1'b1, 1'b0, 32'h12,  32'h0,         1'b1, 32'hDEAD_BEEF);
        test_op("read_10_again",   1'b1, 1'b0, 32'h10,  32'h0,         1'b0, 32'hDEAD_BEEF);
        test_op("read_range",      1'b1, 1'b0, 32'h100, 32'h0,         1'b1, 32'hDEAD_BEEF);
        test_op("both_rd_wr",      1'b1, 1'b1, 32'h8,   32'hCAFE_F00D, 1'b1, 32'hDEAD_BEEF);
        test_op("read_08",         1'b1, 1'b0, 32'h8,   32'h0,         1'b0, 32'h0);
        test_op("read_14",         1'b1, 1'b0, 32'h14,  32'h0,         1'b0, 32'h1111_1111);
    endtask

    task automatic test_reset_mid_op;
        logic saw_done;
        @(posedge clk); #1;
        mem_write = 1'b1; addr = 32'h20; data = 32'h1234_5678;
        @(posedge clk); #1;
        mem_write = 1'b0; addr = 32'h0; data = 32'h0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_cnt++;
        if (busy !== 1'b0) $display("FAIL midrst_busy_in_rst: got %b expected 0", busy);
        else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check_cnt++;
        if (saw_done !== 1'b0) $display("FAIL midrst_no_done: got done=%b expected 0", saw_done);
        else pass_cnt++;
        check_cnt++;
        if (busy !== 1'b0) $display("FAIL midrst_idle: got busy=%b expected 0", busy);
        else pass_cnt++;
        $display("midrst: saw_done=%b busy=%b", saw_done, busy);
        test_op("read_20_after_rst", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic test_back_to_back;
        logic        t_rd   [9];
        logic        t_wr   [9];
        logic [31:0] t_addr [9];
        logic [31:0] t_data [9];
        logic        e_busy [9];
        logic        e_done [9];
        logic        e_chk  [9];
        logic [31:0] e_dm   [9];
        t_rd   = '{0, 0, 0, 1, 1, 1, 1, 0, 0};
        t_wr   = '{1, 1, 1, 0, 0, 0, 0, 0, 0};
        t_addr = '{32'h0, 32'h4, 32'h4, 32'h0, 32'h0, 32'h4, 32'h4, 32'h0, 32'h0};
        t_data = '{32'hA5A5_0000, 32'h0000_5A5A, 32'h0000_5A5A, 32'h0,
                   32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        e_busy = '{1, 0, 1, 0, 1, 0, 1, 0, 0};
        e_done = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
        e_chk  = '{0, 0, 0, 0, 0, 1, 1, 1, 1};
        e_dm   = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                   32'hA5A5_0000, 32'hA5A5_0000, 32'h0000_5A5A, 32'h0000_5A5A};
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            mem_read0 = t_rd[k]; mem_write0 = t_wr[k]; addr0 = t_addr[k]; data0 = t_data[k];
            @(negedge clk);
            check_cnt++;
            if (busy0 !== e_busy[k]) $display("FAIL b2b_busy[%0d]: got %b expected %b", k, busy0, e_busy[k]);
            else pass_cnt++;
            check_cnt++;
            if (done0 !== e_done[k]) $display("FAIL b2b_done[%0d]: got %b expected %b", k, done0, e_done[k]);
            else pass_cnt++;
            check_cnt++;
            if (err0 !== 1'b0) $display("FAIL b2b_err[%0d]: got %b expected 0", k, err0);
            else pass_cnt++;
            if (e_chk[k]) begin
                check_cnt++;
                if (dm_data0 !== e_dm[k]) $display("FAIL b2b_dm[%0d]: got %h expected %h", k, dm_data0, e_dm[k]);
                else pass_cnt++;
            end
            $display("b2b cycle %0d: rd=%b wr=%b addr=%h busy=%b done=%b DM_data=%h",
                     k, t_rd[k], t_wr[k], t_addr[k], busy0, done0, dm_data0);
        end
    endtask

    initial begin
        rst = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; addr = 32'h0; data = 32'h0;
        mem_read0 = 1'b0; mem_write0 = 1'b0; addr0 = 32'h0; data0 = 32'h0;
        test_reset();
        test_write_read();
        test_errors();
        test_reset_mid_op();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/dm_responder.md
DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, meaning word-address width (memory depth 2**ADDR_W words of 32 bits).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning wait-state cycles inserted between request accept and response (legal range 0..15).
REQ-003 SHALL have port clk  input  1  rising-edge clock, the block's only clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port MemRead  input  1  read request from pipeline MEM stage.
REQ-006 SHALL have port MemWrite  input  1  write request from pipeline MEM stage.
REQ-007 SHALL have port addr  input  32  byte address; word index = addr[ADDR_W+1:2].
REQ-008 SHALL have port data  input  32  write data.
REQ-009 SHALL have port DM_data  output  32  read data, registered.
REQ-010 SHALL have port busy  output  1  stall request to pipeline (PC, IF/ID, ID/EX, EX/MEM hold while high).
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port err  output  1  one-cycle error pulse, coincident with done.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-014 In IDLE, a request (MemRead|MemWrite) SHALL be accepted at the rising edge; addr, data, and type are captured; later input changes are ignored until return to IDLE.
REQ-015 On accept: WAIT_CYCLES>0 -> WAIT with counter = WAIT_CYCLES-1; WAIT_CYCLES=0 -> RESP directly.
REQ-016 In WAIT, counter SHALL decrement each cycle; counter==0 -> RESP at next edge.
REQ-017 RESP SHALL last exactly one cycle, then return to IDLE.
REQ-018 done SHALL be 1 only in RESP; total latency from accept edge to done = WAIT_CYCLES+1 cycles.
REQ-019 busy SHALL be combinational: 1 when (IDLE and request present) or state==WAIT; 0 in RESP and in idle with no request.
REQ-020 Write SHALL commit to memory at the edge entering RESP; captured data written at captured word index.
REQ-021 Read SHALL load DM_data at the edge entering RESP; DM_data SHALL hold its value until the next successful read completes (unchanged by writes and errors).
REQ-022 Misaligned address (captured addr[1:0]!=0) SHALL cause no memory access; err=1 in RESP.
REQ-023 Address beyond depth (captured addr[31:ADDR_W+2]!=0) SHALL cause no access; err=1 in RESP.
REQ-024 MemRead and MemWrite both high at accept SHALL be an error: no access, err=1 in RESP.
REQ-025 Read-after-write to same word SHALL return the newly written value (write committed before next accept).
REQ-026 A request still asserted in IDLE after RESP SHALL be treated as a new request.

Reset
REQ-027 When rst=1 at an edge: state=IDLE, counter=0, DM_data=0, done=0, err=0, all memory words=0.
REQ-028 Reset mid-operation (WAIT or RESP) SHALL discard an uncommitted write and abort the pending read; rst dominates any request in the same cycle (no accept).
REQ-029 busy SHALL be 0 while rst=1.

Verification
REQ-030 Reset, then write addr=0x0000_0010 data=0xDEAD_BEEF (WAIT_CYCLES=2) -> busy high 3 cycles incl. request cycle, done pulse 3 cycles after accept, err=0.
REQ-031 Then read addr=0x0000_0010 -> DM_data=0xDEAD_BEEF on done, held through a following write to 0x14.
REQ-032 Read addr=0x0000_0012 -> err=1 with done, DM_data unchanged, memory unchanged.
REQ-033 Read addr=0x0000_0100 (ADDR_W=6) -> err=1; MemRead=MemWrite=1 at addr 0x8 -> err=1, word 2 remains 0.
REQ-034 Write 0x1234_5678 to 0x20, assert rst in the WAIT cycle -> state IDLE, done never pulses, subsequent read of 0x20 returns 0x0000_0000.
REQ-035 WAIT_CYCLES=0: back-to-back reads of 0x0 and 0x4 held continuously -> done on alternate cycles, busy high only in request cycles in IDLE.
